// File: rtl/chess_clock_ctrl_if.sv
// Handshake bundle between the chess clock game controller and its environment.
// master drives clicks/flags/new-game requests; slave is the controller.
interface chess_clock_ctrl_if;
  logic            i_new_game;
  logic [1:0][3:0] i_init;
  logic [1:0]      i_turn;
  logic [1:0]      i_zero;
  logic            o_restart;
  logic [1:0][3:0] o_init;
  logic [1:0]      o_stop;
  logic [1:0]      o_win;
  logic [1:0][3:0] o_moves;
  logic [1:0]      o_state;

  modport master (
    output i_new_game, i_init, i_turn, i_zero,
    input  o_restart, o_init, o_stop, o_win, o_moves, o_state
  );

  modport slave (
    input  i_new_game, i_init, i_turn, i_zero,
    output o_restart, o_init, o_stop, o_win, o_moves, o_state
  );
endinterface

// File: rtl/chess_clock_ctrl.sv
// Two-player chess clock game FSM: selects the running clock, detects flag fall,
// declares the winner, drives restart/start time and keeps a BCD full-move count.
module chess_clock_ctrl #(
  parameter logic [3:0] p_init_hi = 4'd3,
  parameter logic [3:0] p_init_lo = 4'd0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  chess_clock_ctrl_if.slave  bus
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN0 = 2'd1,
    S_RUN1 = 2'd2,
    S_OVER = 2'd3
  } state_t;

  state_t          state_q, state_d;
  logic [1:0][3:0] init_q, init_d;
  logic [1:0][3:0] moves_q, moves_d;
  logic [1:0]      win_q, win_d;
  logic [1:0]      stop_q, stop_d;
  logic            restart_q, restart_d;

  function automatic logic [3:0] clamp_bcd(input logic [3:0] d);
    return (d > 4'd9) ? 4'd9 : d;
  endfunction

  function automatic logic [1:0][3:0] bcd_inc_sat(input logic [1:0][3:0] m);
    logic [1:0][3:0] r;
    r = m;
    if (m[1] == 4'd9 && m[0] == 4'd9) begin
      r = m;
    end else if (m[0] == 4'd9) begin
      r[1] = m[1] + 4'd1;
      r[0] = 4'd0;
    end else begin
      r[0] = m[0] + 4'd1;
    end
    return r;
  endfunction

  always_comb begin
    state_d   = state_q;
    init_d    = init_q;
    moves_d   = moves_q;
    win_d     = win_q;
    restart_d = 1'b0;
    if (bus.i_new_game) begin
      state_d   = S_IDLE;
      init_d[1] = clamp_bcd(bus.i_init[1]);
      init_d[0] = clamp_bcd(bus.i_init[0]);
      moves_d   = '0;
      win_d     = 2'b00;
      restart_d = 1'b1;
    end else begin
      case (state_q)
        // The clicking player hands the clock to the opponent.
        S_IDLE: begin
          if (bus.i_turn == 2'b01)      state_d = S_RUN1;
          else if (bus.i_turn == 2'b10) state_d = S_RUN0;
        end
        S_RUN0: begin
          if (bus.i_zero[0]) begin
            state_d  = S_OVER;
            win_d[1] = 1'b1;
          end else if (bus.i_turn[0]) begin
            state_d = S_RUN1;
          end
        end
        S_RUN1: begin
          if (bus.i_zero[1]) begin
            state_d  = S_OVER;
            win_d[0] = 1'b1;
          end else if (bus.i_turn[1]) begin
            state_d = S_RUN0;
            moves_d = bcd_inc_sat(moves_q);
          end
        end
        default: ;
      endcase
    end
    stop_d = {state_d != S_RUN1, state_d != S_RUN0};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      init_q    <= {p_init_hi, p_init_lo};
      moves_q   <= '0;
      win_q     <= 2'b00;
      stop_q    <= 2'b11;
      restart_q <= 1'b1;
    end else begin
      state_q   <= state_d;
      init_q    <= init_d;
      moves_q   <= moves_d;
      win_q     <= win_d;
      stop_q    <= stop_d;
      restart_q <= restart_d;
    end
  end

  assign bus.o_state   = state_q;
  assign bus.o_init    = init_q;
  assign bus.o_moves   = moves_q;
  assign bus.o_win     = win_q;
  assign bus.o_stop    = stop_q;
  assign bus.o_restart = restart_q;

endmodule

// File: doc/chess_clock_ctrl.md
# chess_clock_ctrl

Game controller for a two-player chess clock built from two `chess_tick_player` instances. It owns the game state machine, decides which clock runs, and gates each player's `i_stop`. It detects flag fall from the players' `o_zero`, declares the winner, and issues the shared `i_restart` pulse and latched start time. It also keeps a BCD full-move counter for display.

## Interface
Parameters:
- `p_init_hi`, default 4'd3: tens digit of the start time loaded by reset.
- `p_init_lo`, default 4'd0: units digit of the start time loaded by reset.

Ports:
- `i_clk`  in  1  system clock.
- `i_rst`  in  1  reset; synchronous, active-high.
- `i_new_game`  in  1  one-cycle pulse; abort the current game and prepare a new one.
- `i_init`  in  [3:0] x [1:0]  requested start time as BCD digits, index 1 = tens; sampled only on `i_new_game`.
- `i_turn`  in  1 x [1:0]  per-player one-cycle click pulses, from player `o_turn`.
- `i_zero`  in  1 x [1:0]  per-player counter-at-zero level, from player `o_zero`.
- `o_restart`  out  1  to both players' `i_restart`.
- `o_init`  out  [3:0] x [1:0]  latched start time, to both players' `i_init`.
- `o_stop`  out  1 x [1:0]  per-player `i_stop`; 1 = clock frozen.
- `o_win`  out  1 x [1:0]  per-player `i_win`.
- `o_moves`  out  [3:0] x [1:0]  BCD full-move count, index 1 = tens.
- `o_state`  out  2  current FSM state, for debug/LED.

## Operation
- **FSM states:** S_IDLE=0, S_RUN0=1, S_RUN1=2, S_OVER=3. Player k's clock runs only in S_RUNk.
- **Priority, highest first:** `i_rst`, then `i_new_game`, then flag fall, then turn.
- **Reset (`i_rst`=1):**
  - state=S_IDLE.
  - `o_init`={p_init_hi,p_init_lo}.
  - `o_moves`=00, `o_win`=00, `o_stop`=11.
  - `o_restart`=1.
- **`i_new_game` (any state):**
  - state←S_IDLE.
  - `o_init`←`i_init`. Invalid BCD digits (>9) are clamped to 9.
  - `o_moves`←00, `o_win`←00, `o_stop`←11.
  - `o_restart` high for exactly 1 cycle.
- **S_IDLE:**
  - `i_turn[k]` alone → S_RUN(1-k). The player who presses starts the opponent's clock.
  - `i_turn`=11 in the same cycle is ignored.
  - `i_zero` is ignored.
- **S_RUNk, flag fall:** `i_zero[k]`=1 → S_OVER and `o_win[1-k]`←1. This wins even if `i_turn[k]` fires in the same cycle.
- **S_RUNk, turn:**
  - `i_turn[k]` (running player) → S_RUN(1-k).
  - `i_turn[1-k]` (waiting player) is ignored.
  - `i_turn`=11 is treated as `i_turn[k]` only.
- **Move counter:**
  - Increments on each S_RUN1→S_RUN0 transition, as a BCD two-digit count.
  - Saturates at 99 and never wraps.
  - The first IDLE→RUN transition does not count.
- **S_OVER:**
  - `o_stop`=11.
  - `o_win` is held.
  - All `i_turn`/`i_zero` are ignored until `i_new_game` or `i_rst`.
- **Output decode:** `o_stop[k]`=~(state==S_RUNk). All outputs are registered.

## Timing
- **Latency:** 1 cycle from a qualifying input edge (sampled at posedge) to the state and `o_stop`/`o_win`/`o_moves` change.
- **Restart pulse:**
  - `i_new_game` at edge n gives `o_restart`=1 during cycle n+1 only.
  - `o_init` is updated at the same edge, so players load the new value with the restart.
- **Reset:** `o_restart` stays 1 while `i_rst` is held, and drops on the first edge with `i_rst`=0.
- **New game mid-run:**
  - The stopped clock keeps its value until the player's restart reloads it on the next edge.
  - `o_stop` goes 11 in the same cycle as `o_restart`.
- **`i_zero` after restart:** may remain stale for 1 cycle after `o_restart`. The FSM is in S_IDLE then, so it is ignored.
- **Back-to-back turn pulses** on consecutive cycles are each honoured, e.g. a RUN0→RUN1→RUN0 sequence in 2 cycles.

## Test plan
- **Reset and start:** reset, then `i_turn[1]`. Expect `o_restart`=1 during reset with `o_init`=30, `o_stop`=11. After the turn: state=S_RUN0, `o_stop`=10, `o_moves`=00.
- **Alternation and move count:**
  - From S_RUN0, alternate `i_turn[0]`/`i_turn[1]` 3 full moves → `o_moves`=03.
  - Inject `i_turn[1]` during S_RUN0 → no change.
- **Flag fall:**
  - In S_RUN1, assert `i_zero[1]` together with `i_turn[1]` → S_OVER, `o_win`=01, `o_stop`=11.
  - Further turns are ignored.
- **Saturation:** drive 101 full moves → `o_moves` holds 99.
- **New game mid-run with clamping:**
  - In S_RUN0 with `o_moves`=05, pulse `i_new_game` with `i_init`={4'd12,4'd5}.
  - Next cycle: `o_restart`=1 for one cycle, `o_init`=95, `o_moves`=00, S_IDLE.
- **Simultaneous presses in idle:** `i_turn`=11 in S_IDLE → stays in S_IDLE. A later single `i_turn[0]` → S_RUN1.
